// File: rtl/pat_seq_ctrl.sv
// Sequencer for the 4-bit pattern generator: clear, seed, step len times, and score
// each generator sample against a masked target. Reports the match count, the first-hit index and per-sample hits.
module pat_seq_ctrl #(
  parameter int PG_LAT = 1,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       seed,
  input  logic [3:0]       target,
  input  logic [3:0]       target_mask,
  input  logic [LEN_W-1:0] len,
  input  logic [2:0]       r_cfg,
  input  logic [2:0]       b_cfg,
  input  logic             b_inc,
  input  logic [3:0]       pg_data_out,
  output logic             pg_res,
  output logic             pg_sel,
  output logic [3:0]       pg_data_in,
  output logic [2:0]       pg_r,
  output logic [2:0]       pg_b,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic [LEN_W-1:0] first_hit_idx,
  output logic             first_hit_vld
);
  localparam int DW = (PG_LAT > 1) ? $clog2(PG_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      state, state_nxt;
  logic [3:0]                  seed_q, tgt_q, msk_q;
  logic [LEN_W-1:0]            len_q, step_idx;
  logic [2:0]                  r_q, b_q;
  logic                        binc_q;
  logic [DW-1:0]               drain_cnt;
  logic [PG_LAT:1]             vld_pipe;
  logic [PG_LAT:1][LEN_W-1:0]  idx_pipe;
  logic                        start_ok, abort_now, issue, cmp_hit;

  assign start_ok  = (state == S_IDLE) && start;
  assign abort_now = (state != S_IDLE) && abort;
  assign issue     = (state == S_LOAD) || (state == S_RUN);
  // A sample whose tag emerges in the abort cycle is dropped along with the flushed pipe.
  assign cmp_hit   = vld_pipe[PG_LAT] && (((pg_data_out ^ tgt_q) & msk_q) == 4'h0) && !abort_now;

  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_CLR;
      S_CLR:   state_nxt = S_LOAD;
      S_LOAD:  state_nxt = (len_q != '0) ? S_RUN : S_DRAIN;
      S_RUN:   if (step_idx == len_q) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == DW'(PG_LAT - 1)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort_now) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      pg_res        <= 1'b0;
      pg_sel        <= 1'b0;
      pg_data_in    <= '0;
      pg_r          <= '0;
      pg_b          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hit           <= 1'b0;
      match_cnt     <= '0;
      first_hit_idx <= '1;
      first_hit_vld <= 1'b0;
      seed_q        <= '0;
      tgt_q         <= '0;
      msk_q         <= '0;
      len_q         <= '0;
      r_q           <= '0;
      b_q           <= '0;
      binc_q        <= 1'b0;
      step_idx      <= '0;
      drain_cnt     <= '0;
      vld_pipe      <= '0;
      idx_pipe      <= '0;
    end else begin
      // Outputs are registered from the next state so they line up with the state they describe.
      pg_res <= (state_nxt == S_CLR) || abort_now;
      pg_sel <= (state_nxt == S_LOAD);
      busy   <= (state_nxt != S_IDLE);
      done   <= (state_nxt == S_DONE);
      hit    <= cmp_hit;

      if (state_nxt == S_LOAD) begin
        pg_data_in <= seed_q;
        pg_r       <= r_q;
        pg_b       <= b_q;
      end else if (issue && state_nxt == S_RUN && binc_q) begin
        pg_b <= pg_b + 3'd1;
      end

      if (state_nxt == S_LOAD) step_idx <= '0;
      else if (issue)          step_idx <= step_idx + LEN_W'(1);

      drain_cnt <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;

      for (int i = PG_LAT; i > 1; i--) begin
        vld_pipe[i] <= vld_pipe[i-1] && !abort_now;
        idx_pipe[i] <= idx_pipe[i-1];
      end
      vld_pipe[1] <= issue && !abort_now;
      idx_pipe[1] <= step_idx;

      if (start_ok) begin
        seed_q        <= seed;
        tgt_q         <= target;
        msk_q         <= target_mask;
        len_q         <= len;
        r_q           <= r_cfg;
        b_q           <= b_cfg;
        binc_q        <= b_inc;
        match_cnt     <= '0;
        first_hit_idx <= '1;
        first_hit_vld <= 1'b0;
      end else if (cmp_hit) begin
        if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
        if (!first_hit_vld) begin
          first_hit_vld <= 1'b1;
          first_hit_idx <= idx_pipe[PG_LAT];
        end
      end
    end
  end
endmodule

// File: tb/tb_pat_seq_ctrl.sv
// Bench for pat_seq_ctrl: two instances (PG_LAT=1/CNT_W=8 and PG_LAT=2/CNT_W=2) share stimulus,
// each driven by a generator stub; results are scored against a sample-list reference model.
module tb_pat_seq_ctrl;
  localparam int LAT_A = 1, LAT_B = 2, CW_A = 8, CW_B = 2;
  localparam logic [31:0] RST_A = {23'd0, 8'hff, 1'b0};
  localparam logic [25:0] RST_B = {17'd0, 8'hff, 1'b0};

  logic clk = 1'b0;
  logic res = 1'b0;
  always #5 clk = ~clk;

  logic       start, abort, b_inc;
  logic [3:0] seed, target, target_mask;
  logic [7:0] len;
  logic [2:0] r_cfg, b_cfg;

  logic       pg_res_a, pg_sel_a, busy_a, done_a, hit_a, first_hit_vld_a;
  logic [3:0] pg_data_in_a, pg_data_out_a;
  logic [2:0] pg_r_a, pg_b_a;
  logic [7:0] match_cnt_a, first_hit_idx_a;
  logic       pg_res_b, pg_sel_b, busy_b, done_b, hit_b, first_hit_vld_b;
  logic [3:0] pg_data_in_b, pg_data_out_b;
  logic [2:0] pg_r_b, pg_b_b;
  logic [1:0] match_cnt_b;
  logic [7:0] first_hit_idx_b;

  pat_seq_ctrl #(.PG_LAT(LAT_A), .LEN_W(8), .CNT_W(CW_A)) dut_a (
    .clk(clk), .res(res), .start(start), .abort(abort), .seed(seed), .target(target),
    .target_mask(target_mask), .len(len), .r_cfg(r_cfg), .b_cfg(b_cfg), .b_inc(b_inc),
    .pg_data_out(pg_data_out_a), .pg_res(pg_res_a), .pg_sel(pg_sel_a), .pg_data_in(pg_data_in_a),
    .pg_r(pg_r_a), .pg_b(pg_b_a), .busy(busy_a), .done(done_a), .hit(hit_a),
    .match_cnt(match_cnt_a), .first_hit_idx(first_hit_idx_a), .first_hit_vld(first_hit_vld_a));

  pat_seq_ctrl #(.PG_LAT(LAT_B), .LEN_W(8), .CNT_W(CW_B)) dut_b (
    .clk(clk), .res(res), .start(start), .abort(abort), .seed(seed), .target(target),
    .target_mask(target_mask), .len(len), .r_cfg(r_cfg), .b_cfg(b_cfg), .b_inc(b_inc),
    .pg_data_out(pg_data_out_b), .pg_res(pg_res_b), .pg_sel(pg_sel_b), .pg_data_in(pg_data_in_b),
    .pg_r(pg_r_b), .pg_b(pg_b_b), .busy(busy_b), .done(done_b), .hit(hit_b),
    .match_cnt(match_cnt_b), .first_hit_idx(first_hit_idx_b), .first_hit_vld(first_hit_vld_b));

  logic [31:0] vec_a;
  logic [25:0] vec_b;
  assign vec_a = {pg_res_a, pg_sel_a, pg_data_in_a, pg_r_a, pg_b_a, busy_a, done_a, hit_a,
                  match_cnt_a, first_hit_idx_a, first_hit_vld_a};
  assign vec_b = {pg_res_b, pg_sel_b, pg_data_in_b, pg_r_b, pg_b_b, busy_b, done_b, hit_b,
                  match_cnt_b, first_hit_idx_b, first_hit_vld_b};

  // Run configuration; c_mode selects the stub: 0 = constant A, 1 = step index, 2 = rotate/add generator.
  int         c_mode, c_len;
  logic [3:0] c_seed, c_tgt, c_msk;
  logic [2:0] c_r, c_b;
  logic       c_binc;
  int         n_chk = 0, n_fail = 0;

  function automatic logic [3:0] rotl(logic [3:0] x, logic [2:0] r);
    logic [3:0] y = x;
    for (int k = 0; k < int'(r); k++) y = {y[2:0], y[3]};
    return y;
  endfunction

  function automatic logic [3:0] stub_next(logic [3:0] g, logic rs, logic sel, logic [3:0] din,
                                           logic [2:0] r, logic [2:0] b);
    if (rs) return 4'h0;
    if (sel) return (c_mode == 1) ? 4'h0 : din;
    if (c_mode == 1) return g + 4'h1;
    return rotl(g, r) + {1'b0, b};
  endfunction

  logic [3:0] g_a, g_b, q_b;
  always_ff @(posedge clk) begin
    g_a <= stub_next(g_a, pg_res_a, pg_sel_a, pg_data_in_a, pg_r_a, pg_b_a);
    g_b <= stub_next(g_b, pg_res_b, pg_sel_b, pg_data_in_b, pg_r_b, pg_b_b);
    q_b <= g_b;
  end
  assign pg_data_out_a = (c_mode == 0) ? 4'hA : g_a;
  assign pg_data_out_b = (c_mode == 0) ? 4'hA : q_b;

  // Reference: list of len+1 samples, scored up to the last one compared before an abort.
  task automatic model(input logic [3:0] samp [0:255], input int lat, input int abort_at,
                       output int m, output int first);
    int last = c_len;
    if (abort_at >= 0 && abort_at - 2 - lat < last) last = abort_at - 2 - lat;
    m = 0;
    first = 255;
    for (int i = 0; i <= last; i++)
      if (((samp[i] ^ c_tgt) & c_msk) == 4'h0) begin
        if (m == 0) first = i;
        m++;
      end
  endtask

  task automatic do_run(input string name, input int abort_at, input int restart_at, input bit ab_start);
    logic [3:0] samp [0:255];
    logic [3:0] x = c_seed;
    logic [2:0] bi, eb;
    int m_a, f_a, m_b, f_b, end_c;
    int done_a_c = -1, done_b_c = -1, n_done_a = 0, n_done_b = 0, hits_a = 0, hits_b = 0, sel_cnt = 0;
    bit clr_seen = 0, ab_seen = 0, pgb_ok = 1, load_ok = 1;
    for (int i = 0; i <= c_len; i++) begin
      bi = c_binc ? 3'(int'(c_b) + i) : c_b;
      if (i > 0) x = rotl(x, c_r) + {1'b0, bi};
      samp[i] = (c_mode == 0) ? 4'hA : (c_mode == 1) ? 4'(i) : x;
    end
    model(samp, LAT_A, abort_at, m_a, f_a);
    model(samp, LAT_B, abort_at, m_b, f_b);

    @(negedge clk);
    seed = c_seed; target = c_tgt; target_mask = c_msk; len = 8'(c_len);
    r_cfg = c_r; b_cfg = c_b; b_inc = c_binc; start = 1'b1; abort = ab_start;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    {seed, target, target_mask} = 12'($urandom);
    len = 8'($urandom); r_cfg = 3'($urandom); b_cfg = 3'($urandom); b_inc = 1'($urandom);
    end_c = (abort_at >= 0) ? abort_at + 8 : c_len + 2 + LAT_B + 4;
    for (int c = 0; c <= end_c; c++) begin
      if (c == 0) clr_seen = pg_res_a && pg_res_b && busy_a && busy_b && !pg_sel_a;
      if (abort_at >= 0 && c == abort_at + 1) ab_seen = pg_res_a && pg_res_b && !busy_a && !busy_b;
      if (done_a) begin n_done_a++; done_a_c = c; end
      if (done_b) begin n_done_b++; done_b_c = c; end
      hits_a += int'(hit_a);
      hits_b += int'(hit_b);
      sel_cnt += int'(pg_sel_a);
      if (abort_at < 0 && c >= 1 && c <= c_len + 1) begin
        eb = c_binc ? 3'(int'(c_b) + c - 1) : c_b;
        if (pg_b_a !== eb || pg_b_b !== eb || pg_r_a !== c_r) pgb_ok = 0;
      end
      if (c == 1 && (pg_sel_a !== 1'b1 || pg_data_in_a !== c_seed || pg_sel_b !== 1'b1)) load_ok = 0;
      abort = (c == abort_at);
      start = (c == restart_at);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;

    n_chk++;
    if (!clr_seen) begin n_fail++; $display("FAIL %s clr_cycle: got pg_res=%b busy=%b want 1 1", name, pg_res_a, busy_a); end
    if (abort_at >= 0) begin
      n_chk++;
      if (n_done_a + n_done_b != 0) begin n_fail++; $display("FAIL %s done_on_abort: got %0d pulses want 0", name, n_done_a + n_done_b); end
      n_chk++;
      if (!ab_seen) begin n_fail++; $display("FAIL %s abort_idle: pg_res/idle not seen after abort (want pg_res=1 busy=0)", name); end
    end else begin
      n_chk++;
      if (done_a_c != 2 + c_len + LAT_A || n_done_a != 1) begin
        n_fail++; $display("FAIL %s done_a: got cycle %0d x%0d want cycle %0d x1", name, done_a_c, n_done_a, 2 + c_len + LAT_A); end
      n_chk++;
      if (done_b_c != 2 + c_len + LAT_B || n_done_b != 1) begin
        n_fail++; $display("FAIL %s done_b: got cycle %0d x%0d want cycle %0d x1", name, done_b_c, n_done_b, 2 + c_len + LAT_B); end
      n_chk++;
      if (sel_cnt != 1 || !load_ok) begin n_fail++; $display("FAIL %s load: got pg_sel cycles %0d load_ok %0d want 1 1", name, sel_cnt, load_ok); end
      n_chk++;
      if (!pgb_ok) begin n_fail++; $display("FAIL %s pg_b_seq: got mismatching pg_b/pg_r, want b_cfg+step (binc=%0d)", name, c_binc); end
    end
    n_chk++;
    if (match_cnt_a !== 8'((m_a > 255) ? 255 : m_a)) begin n_fail++; $display("FAIL %s match_cnt_a: got %0d want %0d", name, match_cnt_a, (m_a > 255) ? 255 : m_a); end
    n_chk++;
    if (match_cnt_b !== 2'((m_b > 3) ? 3 : m_b)) begin n_fail++; $display("FAIL %s match_cnt_b: got %0d want %0d", name, match_cnt_b, (m_b > 3) ? 3 : m_b); end
    n_chk++;
    if (first_hit_idx_a !== 8'(f_a) || first_hit_vld_a !== (m_a > 0)) begin
      n_fail++; $display("FAIL %s first_a: got %0d/%b want %0d/%b", name, first_hit_idx_a, first_hit_vld_a, f_a, m_a > 0); end
    n_chk++;
    if (first_hit_idx_b !== 8'(f_b) || first_hit_vld_b !== (m_b > 0)) begin
      n_fail++; $display("FAIL %s first_b: got %0d/%b want %0d/%b", name, first_hit_idx_b, first_hit_vld_b, f_b, m_b > 0); end
    n_chk++;
    if (hits_a != m_a || hits_b != m_b) begin n_fail++; $display("FAIL %s hit_pulses: got %0d/%0d want %0d/%0d", name, hits_a, hits_b, m_a, m_b); end
    n_chk++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin n_fail++; $display("FAIL %s idle_after: got busy %b%b want 00", name, busy_a, busy_b); end
  endtask

  task automatic set_cfg(input int mode, input logic [3:0] sd, tg, mk, input int ln,
                         input logic [2:0] r, b, input logic bc);
    c_mode = mode; c_seed = sd; c_tgt = tg; c_msk = mk; c_len = ln; c_r = r; c_b = b; c_binc = bc;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (vec_a !== RST_A) begin n_fail++; $display("FAIL reset_a: got %h want %h", vec_a, RST_A); end
    n_chk++;
    if (vec_b !== RST_B) begin n_fail++; $display("FAIL reset_b: got %h want %h", vec_b, RST_B); end
    @(negedge clk) res = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_const;
    set_cfg(0, 4'h3, 4'hA, 4'hF, 5, 3'd1, 3'd2, 1'b0);
    do_run("const", -1, -1, 0);
  endtask

  task automatic test_index;
    set_cfg(1, 4'h0, 4'h3, 4'hF, 7, 3'd0, 3'd0, 1'b0);
    do_run("index_fullmask", -1, -1, 0);
    set_cfg(1, 4'h0, 4'h3, 4'h1, 7, 3'd0, 3'd0, 1'b0);
    do_run("index_lsbmask", -1, -1, 0);
  endtask

  task automatic test_len0;
    set_cfg(2, 4'h9, 4'h9, 4'hF, 0, 3'd2, 3'd5, 1'b1);
    do_run("len0", -1, -1, 0);
  endtask

  task automatic test_binc;
    set_cfg(2, 4'h5, 4'h0, 4'h3, 4, 3'd1, 3'd6, 1'b1);
    do_run("binc_on", -1, -1, 0);
    set_cfg(2, 4'h5, 4'h0, 4'h3, 4, 3'd1, 3'd6, 1'b0);
    do_run("binc_off", -1, -1, 0);
  endtask

  task automatic test_abort;
    set_cfg(0, 4'h0, 4'hA, 4'hF, 10, 3'd0, 3'd0, 1'b0);
    do_run("abort_run3", 4, -1, 0);
    set_cfg(1, 4'h0, 4'h2, 4'h2, 9, 3'd0, 3'd0, 1'b0);
    do_run("after_abort", -1, -1, 0);
  endtask

  task automatic test_busy_start;
    set_cfg(0, 4'h0, 4'hA, 4'hE, 6, 3'd0, 3'd0, 1'b0);
    do_run("start_abort_idle_busy_start", -1, 3, 1);
  endtask

  task automatic test_async_reset;
    bit seen_act = 0;
    @(negedge clk);
    seed = 4'h1; target = 4'hA; target_mask = 4'hF; len = 8'd10; r_cfg = 3'd0; b_cfg = 3'd0; b_inc = 1'b0;
    c_mode = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #4;
    res = 1'b0;
    #1;
    n_chk++;
    if (vec_a !== RST_A) begin n_fail++; $display("FAIL async_reset_a: got %h want %h", vec_a, RST_A); end
    n_chk++;
    if (vec_b !== RST_B) begin n_fail++; $display("FAIL async_reset_b: got %h want %h", vec_b, RST_B); end
    @(negedge clk) res = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (done_a || done_b || busy_a || busy_b) seen_act = 1;
    end
    n_chk++;
    if (seen_act) begin n_fail++; $display("FAIL async_reset_quiet: got done/busy activity want none"); end
  endtask

  task automatic test_random;
    int ab;
    for (int k = 0; k < 12; k++) begin
      set_cfg(2, 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 24)),
              3'($urandom), 3'($urandom), 1'($urandom));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c_len + 2)) : -1;
      do_run($sformatf("random%0d", k), ab, -1, 0);
    end
  endtask

  task automatic test_len_max;
    set_cfg(2, 4'hC, 4'h0, 4'h0, 255, 3'd3, 3'd1, 1'b1);
    do_run("len_max", -1, -1, 0);
  endtask

  initial begin
    start = 1'b0; abort = 1'b0; seed = '0; target = '0; target_mask = '0; len = '0;
    r_cfg = '0; b_cfg = '0; b_inc = 1'b0;
    c_mode = 0; c_len = 0; c_seed = '0; c_tgt = '0; c_msk = '0; c_r = '0; c_b = '0; c_binc = 1'b0;
    test_reset();
    test_const();
    test_index();
    test_len0();
    test_binc();
    test_abort();
    test_busy_start();
    test_async_reset();
    test_random();
    test_len_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
